// File: rtl/ami_port_arbiter_pkg.sv
// Shared AMI request/response types and sizing constants for the memory-port
// arbiter and its neighbours.
package AMITypes;
  localparam int AMI_NUM_APPS          = 4;
  localparam int AMI_ADDR_WIDTH        = 64;
  localparam int AMI_DATA_WIDTH        = 512;
  localparam int AMI_ARB_ROUTE_Q_DEPTH = 16;

  typedef struct packed {
    logic                      valid;
    logic                      isWrite;
    logic [AMI_ADDR_WIDTH-1:0] addr;
    logic [AMI_DATA_WIDTH-1:0] data;
    logic [5:0]                size;
  } AMIRequest;

  typedef struct packed {
    logic                      valid;
    logic [AMI_DATA_WIDTH-1:0] data;
    logic [5:0]                size;
  } AMIResponse;
endpackage

// File: rtl/ami_port_arbiter_route_fifo.sv
// In-order queue of requester IDs for reads still awaiting a response.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module ami_route_fifo #(
  parameter  int ID_W  = 2,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic [ID_W-1:0] head
);
  logic [DEPTH-1:0][ID_W-1:0] mem_q, mem_d;
  logic [AW:0]                wptr_q, wptr_d, rptr_q, rptr_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push && !full) begin
      mem_d[wptr_q[AW-1:0]] = push_id;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (pop && !empty) rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/ami_port_arbiter.sv
// Round-robin share of one AMI memory port between N_REQ requesters; read
// responses are steered back in issue order through a route FIFO of IDs.
module ami_port_arbiter import AMITypes::*; #(
  parameter  int N_REQ         = AMI_NUM_APPS,
  parameter  int ROUTE_Q_DEPTH = AMI_ARB_ROUTE_Q_DEPTH,
  parameter  int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW            = $clog2(ROUTE_Q_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  AMIRequest  [N_REQ-1:0] app_req,
  output logic       [N_REQ-1:0] app_req_grant,
  output AMIRequest              mem_req,
  input  logic                   mem_req_grant,
  input  AMIResponse             mem_resp,
  output logic                   mem_resp_grant,
  output AMIResponse [N_REQ-1:0] app_resp,
  input  logic       [N_REQ-1:0] app_resp_grant,
  output logic       [CW-1:0]    outstanding,
  output logic                   err_orphan
);
  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] el,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (el[idx]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  AMIRequest        mem_req_q, mem_req_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             err_orphan_q, err_orphan_d;
  logic [N_REQ-1:0] elig;
  logic             slot_ld, found, push, pop;
  logic [ID_W-1:0]  win, head;
  logic             route_full, route_empty;

  always_comb begin
    slot_ld = !mem_req_q.valid || mem_req_grant;
    for (int i = 0; i < N_REQ; i++)
      elig[i] = app_req[i].valid && (app_req[i].isWrite || !route_full);
    {found, win}  = rr_pick(elig, rr_ptr_q);
    app_req_grant = '0;
    mem_req_d     = mem_req_q;
    rr_ptr_d      = rr_ptr_q;
    push          = 1'b0;
    if (slot_ld) begin
      mem_req_d.valid = 1'b0;
      if (found) begin
        mem_req_d = app_req[win];
        rr_ptr_d  = (int'(win) == N_REQ - 1) ? '0 : win + ID_W'(1);
        push      = !app_req[win].isWrite;
        // Grants are outputs; hold them low while reset is asserted.
        app_req_grant[win] = !rst;
      end
    end
  end

  always_comb begin
    app_resp       = '0;
    mem_resp_grant = 1'b0;
    pop            = 1'b0;
    err_orphan_d   = err_orphan_q;
    if (!route_empty) begin
      app_resp[head] = mem_resp;
      mem_resp_grant = app_resp_grant[head] && !rst;
      pop            = mem_resp.valid && app_resp_grant[head];
    end else if (mem_resp.valid) begin
      // Nobody to route to: swallow the beat and flag it.
      mem_resp_grant = !rst;
      err_orphan_d   = 1'b1;
    end
  end

  ami_route_fifo #(.ID_W(ID_W), .DEPTH(ROUTE_Q_DEPTH)) u_route_q (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (win),
    .pop     (pop),
    .full    (route_full),
    .empty   (route_empty),
    .count   (outstanding),
    .head    (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q    <= '0;
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      mem_req_q    <= mem_req_d;
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign err_orphan = err_orphan_q;
endmodule
